// File: rtl/ctrl_pipe_hazard_if.sv
// Decode-stage control word in, pipelined controls plus hazard/forwarding selects out.
// slave is the hazard unit's view; master is the controller/datapath side.
interface ctrl_pipe_hazard_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             mem_to_reg_i;
  logic             enable_wmem_i;
  logic             b_alu_input_i;
  logic             reg_dst_rtrd_i;
  logic             enable_wreg_i;
  logic             apply_shift_i;
  logic [1:0]       alu_alt_ctrl_i2;
  logic             branch_i;
  logic             pc_beq_i;
  logic             pc_j_i;
  logic [4:0]       rs_d_i5;
  logic [4:0]       rt_d_i5;
  logic [4:0]       rd_d_i5;

  logic             e_mem_to_reg_o;
  logic             e_enable_wmem_o;
  logic             e_b_alu_input_o;
  logic             e_enable_wreg_o;
  logic             e_apply_shift_o;
  logic [1:0]       e_alu_alt_ctrl_o2;
  logic [4:0]       e_write_reg_o5;
  logic             m_mem_to_reg_o;
  logic             m_enable_wmem_o;
  logic             m_enable_wreg_o;
  logic [4:0]       m_write_reg_o5;
  logic             w_mem_to_reg_o;
  logic             w_enable_wreg_o;
  logic [4:0]       w_write_reg_o5;
  logic             stall_f_o;
  logic             stall_d_o;
  logic             flush_e_o;
  logic             flush_d_o;
  logic             forward_ad_o;
  logic             forward_bd_o;
  logic [1:0]       forward_ae_o2;
  logic [1:0]       forward_be_o2;
  logic [CNT_W-1:0] bubble_cnt_o;

  modport master (
    output mem_to_reg_i, enable_wmem_i, b_alu_input_i, reg_dst_rtrd_i, enable_wreg_i,
           apply_shift_i, alu_alt_ctrl_i2, branch_i, pc_beq_i, pc_j_i, rs_d_i5, rt_d_i5, rd_d_i5,
    input  e_mem_to_reg_o, e_enable_wmem_o, e_b_alu_input_o, e_enable_wreg_o, e_apply_shift_o,
           e_alu_alt_ctrl_o2, e_write_reg_o5, m_mem_to_reg_o, m_enable_wmem_o, m_enable_wreg_o,
           m_write_reg_o5, w_mem_to_reg_o, w_enable_wreg_o, w_write_reg_o5, stall_f_o,
           stall_d_o, flush_e_o, flush_d_o, forward_ad_o, forward_bd_o, forward_ae_o2,
           forward_be_o2, bubble_cnt_o
  );

  modport slave (
    input  mem_to_reg_i, enable_wmem_i, b_alu_input_i, reg_dst_rtrd_i, enable_wreg_i,
           apply_shift_i, alu_alt_ctrl_i2, branch_i, pc_beq_i, pc_j_i, rs_d_i5, rt_d_i5, rd_d_i5,
    output e_mem_to_reg_o, e_enable_wmem_o, e_b_alu_input_o, e_enable_wreg_o, e_apply_shift_o,
           e_alu_alt_ctrl_o2, e_write_reg_o5, m_mem_to_reg_o, m_enable_wmem_o, m_enable_wreg_o,
           m_write_reg_o5, w_mem_to_reg_o, w_enable_wreg_o, w_write_reg_o5, stall_f_o,
           stall_d_o, flush_e_o, flush_d_o, forward_ad_o, forward_bd_o, forward_ae_o2,
           forward_be_o2, bubble_cnt_o
  );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// D->E->M->W control pipeline with load-use / branch hazard detection, forwarding
// selects and a saturating bubble counter.
module ctrl_pipe_hazard #(
  parameter int unsigned CNT_W = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  ctrl_pipe_hazard_if.slave bus
);
  logic             mem_to_reg_e_q, enable_wmem_e_q, b_alu_input_e_q, reg_dst_rtrd_e_q;
  logic             enable_wreg_e_q, apply_shift_e_q;
  logic [1:0]       alu_alt_ctrl_e_q;
  logic [4:0]       rs_e_q, rt_e_q, rd_e_q;
  logic             mem_to_reg_m_q, enable_wmem_m_q, enable_wreg_m_q;
  logic [4:0]       write_reg_m_q;
  logic             mem_to_reg_w_q, enable_wreg_w_q;
  logic [4:0]       write_reg_w_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  logic [4:0] write_reg_e;
  logic       lw_stall, br_stall, stall;
  logic [1:0] fwd_ae, fwd_be;

  assign write_reg_e = reg_dst_rtrd_e_q ? rd_e_q : rt_e_q;

  // M wins over W; $0 is hard-wired so it never forwards.
  always_comb begin
    fwd_ae = 2'b00;
    if (rs_e_q != 5'd0 && rs_e_q == write_reg_m_q && enable_wreg_m_q) begin
      fwd_ae = 2'b10;
    end else if (rs_e_q != 5'd0 && rs_e_q == write_reg_w_q && enable_wreg_w_q) begin
      fwd_ae = 2'b01;
    end
    fwd_be = 2'b00;
    if (rt_e_q != 5'd0 && rt_e_q == write_reg_m_q && enable_wreg_m_q) begin
      fwd_be = 2'b10;
    end else if (rt_e_q != 5'd0 && rt_e_q == write_reg_w_q && enable_wreg_w_q) begin
      fwd_be = 2'b01;
    end
  end

  always_comb begin
    lw_stall = mem_to_reg_e_q && (rt_e_q == bus.rs_d_i5 || rt_e_q == bus.rt_d_i5);
    br_stall = bus.branch_i &&
               ((enable_wreg_e_q && (write_reg_e == bus.rs_d_i5 || write_reg_e == bus.rt_d_i5)) ||
                (mem_to_reg_m_q &&
                 (write_reg_m_q == bus.rs_d_i5 || write_reg_m_q == bus.rt_d_i5)));
    stall    = lw_stall | br_stall;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_to_reg_e_q   <= 1'b0;
      enable_wmem_e_q  <= 1'b0;
      b_alu_input_e_q  <= 1'b0;
      reg_dst_rtrd_e_q <= 1'b0;
      enable_wreg_e_q  <= 1'b0;
      apply_shift_e_q  <= 1'b0;
      alu_alt_ctrl_e_q <= 2'b00;
      rs_e_q           <= 5'd0;
      rt_e_q           <= 5'd0;
      rd_e_q           <= 5'd0;
      mem_to_reg_m_q   <= 1'b0;
      enable_wmem_m_q  <= 1'b0;
      enable_wreg_m_q  <= 1'b0;
      write_reg_m_q    <= 5'd0;
      mem_to_reg_w_q   <= 1'b0;
      enable_wreg_w_q  <= 1'b0;
      write_reg_w_q    <= 5'd0;
      bubble_cnt_q     <= '0;
    end else begin
      if (stall) begin
        mem_to_reg_e_q   <= 1'b0;
        enable_wmem_e_q  <= 1'b0;
        b_alu_input_e_q  <= 1'b0;
        reg_dst_rtrd_e_q <= 1'b0;
        enable_wreg_e_q  <= 1'b0;
        apply_shift_e_q  <= 1'b0;
        alu_alt_ctrl_e_q <= 2'b00;
        rs_e_q           <= 5'd0;
        rt_e_q           <= 5'd0;
        rd_e_q           <= 5'd0;
      end else begin
        mem_to_reg_e_q   <= bus.mem_to_reg_i;
        enable_wmem_e_q  <= bus.enable_wmem_i;
        b_alu_input_e_q  <= bus.b_alu_input_i;
        reg_dst_rtrd_e_q <= bus.reg_dst_rtrd_i;
        enable_wreg_e_q  <= bus.enable_wreg_i;
        apply_shift_e_q  <= bus.apply_shift_i;
        alu_alt_ctrl_e_q <= bus.alu_alt_ctrl_i2;
        rs_e_q           <= bus.rs_d_i5;
        rt_e_q           <= bus.rt_d_i5;
        rd_e_q           <= bus.rd_d_i5;
      end
      mem_to_reg_m_q  <= mem_to_reg_e_q;
      enable_wmem_m_q <= enable_wmem_e_q;
      enable_wreg_m_q <= enable_wreg_e_q;
      write_reg_m_q   <= write_reg_e;
      mem_to_reg_w_q  <= mem_to_reg_m_q;
      enable_wreg_w_q <= enable_wreg_m_q;
      write_reg_w_q   <= write_reg_m_q;
      if (stall && bubble_cnt_q != '1) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.e_mem_to_reg_o    = mem_to_reg_e_q;
  assign bus.e_enable_wmem_o   = enable_wmem_e_q;
  assign bus.e_b_alu_input_o   = b_alu_input_e_q;
  assign bus.e_enable_wreg_o   = enable_wreg_e_q;
  assign bus.e_apply_shift_o   = apply_shift_e_q;
  assign bus.e_alu_alt_ctrl_o2 = alu_alt_ctrl_e_q;
  assign bus.e_write_reg_o5    = write_reg_e;
  assign bus.m_mem_to_reg_o    = mem_to_reg_m_q;
  assign bus.m_enable_wmem_o   = enable_wmem_m_q;
  assign bus.m_enable_wreg_o   = enable_wreg_m_q;
  assign bus.m_write_reg_o5    = write_reg_m_q;
  assign bus.w_mem_to_reg_o    = mem_to_reg_w_q;
  assign bus.w_enable_wreg_o   = enable_wreg_w_q;
  assign bus.w_write_reg_o5    = write_reg_w_q;
  assign bus.stall_f_o         = stall;
  assign bus.stall_d_o         = stall;
  assign bus.flush_e_o         = stall;
  // A taken branch waits for its operands before killing the fetched instruction.
  assign bus.flush_d_o         = (bus.pc_beq_i | bus.pc_j_i) & ~stall;
  assign bus.forward_ad_o      = bus.rs_d_i5 != 5'd0 && bus.rs_d_i5 == write_reg_m_q &&
                                 enable_wreg_m_q;
  assign bus.forward_bd_o      = bus.rt_d_i5 != 5'd0 && bus.rt_d_i5 == write_reg_m_q &&
                                 enable_wreg_m_q;
  assign bus.forward_ae_o2     = fwd_ae;
  assign bus.forward_be_o2     = fwd_be;
  assign bus.bubble_cnt_o      = bubble_cnt_q;
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scoreboard bench for ctrl_pipe_hazard: a CNT_W=16 unit plus a CNT_W=2 copy fed the same
// decode stream so counter saturation can be observed.
module tb_ctrl_pipe_hazard;
  logic clk;
  logic rst_ni;

  ctrl_pipe_hazard_if #(.CNT_W(16)) bus ();
  ctrl_pipe_hazard_if #(.CNT_W(2))  bus2 ();

  ctrl_pipe_hazard #(.CNT_W(16)) u_dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));
  ctrl_pipe_hazard #(.CNT_W(2))  u_sat (.clk_i(clk), .rst_ni(rst_ni), .bus(bus2));

  assign bus2.mem_to_reg_i    = bus.mem_to_reg_i;
  assign bus2.enable_wmem_i   = bus.enable_wmem_i;
  assign bus2.b_alu_input_i   = bus.b_alu_input_i;
  assign bus2.reg_dst_rtrd_i  = bus.reg_dst_rtrd_i;
  assign bus2.enable_wreg_i   = bus.enable_wreg_i;
  assign bus2.apply_shift_i   = bus.apply_shift_i;
  assign bus2.alu_alt_ctrl_i2 = bus.alu_alt_ctrl_i2;
  assign bus2.branch_i        = bus.branch_i;
  assign bus2.pc_beq_i        = bus.pc_beq_i;
  assign bus2.pc_j_i          = bus.pc_j_i;
  assign bus2.rs_d_i5         = bus.rs_d_i5;
  assign bus2.rt_d_i5         = bus.rt_d_i5;
  assign bus2.rd_d_i5         = bus.rd_d_i5;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        it;
  logic [63:0] obs;
  int          checks = 0;
  int          failures = 0;
  int          exp_bubbles = 0;
  logic [1:0]  exp_sat = 2'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string n, input logic [63:0] v);
    exp_t e;
    e.name = n;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic bump_bubble();
    exp_bubbles++;
    exp_sat = (exp_sat == 2'd3) ? 2'd3 : exp_sat + 2'd1;
  endtask

  task automatic drive_d(input logic m2r, input logic wmem, input logic balu, input logic rtrd,
                         input logic wreg, input logic shift, input logic [1:0] alu,
                         input logic br, input logic beq, input logic j,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus.mem_to_reg_i    = m2r;
    bus.enable_wmem_i   = wmem;
    bus.b_alu_input_i   = balu;
    bus.reg_dst_rtrd_i  = rtrd;
    bus.enable_wreg_i   = wreg;
    bus.apply_shift_i   = shift;
    bus.alu_alt_ctrl_i2 = alu;
    bus.branch_i        = br;
    bus.pc_beq_i        = beq;
    bus.pc_j_i          = j;
    bus.rs_d_i5         = rs;
    bus.rt_d_i5         = rt;
    bus.rd_d_i5         = rd;
  endtask

  task automatic clear_d();
    drive_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic randomize_d();
    drive_d(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_d();
    #12 rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      randomize_d();
    end
    @(posedge clk);
    #3;
    randomize_d();
    rst_ni = 1'b0;
    #1;
    push_exp("reset_pipe_regs", 64'd0);
    push_exp("reset_hazard_outs", 64'({11'd0, bus.pc_beq_i | bus.pc_j_i}));
    obs = 64'({bus.e_mem_to_reg_o, bus.e_enable_wmem_o, bus.e_b_alu_input_o,
               bus.e_enable_wreg_o, bus.e_apply_shift_o, bus.e_alu_alt_ctrl_o2,
               bus.e_write_reg_o5, bus.m_mem_to_reg_o, bus.m_enable_wmem_o,
               bus.m_enable_wreg_o, bus.m_write_reg_o5, bus.w_mem_to_reg_o,
               bus.w_enable_wreg_o, bus.w_write_reg_o5, bus.bubble_cnt_o, bus2.bubble_cnt_o});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    obs = 64'({bus.stall_f_o, bus.stall_d_o, bus.flush_e_o, bus.forward_ad_o,
               bus.forward_bd_o, bus.forward_ae_o2, bus.forward_be_o2, bus.flush_d_o});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    clear_d();
    #2 rst_ni = 1'b1;
    exp_bubbles = 0;
    exp_sat     = 2'd0;
  endtask

  task automatic test_latency();
    tick();
    drive_d(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5);
    push_exp("latency_e", 64'({2'b10, 1'b1, 5'd5}));
    push_exp("latency_m", 64'({1'b1, 5'd5}));
    push_exp("latency_w", 64'({1'b1, 5'd5}));
    tick();
    clear_d();
    obs = 64'({bus.e_alu_alt_ctrl_o2, bus.e_enable_wreg_o, bus.e_write_reg_o5});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    tick();
    obs = 64'({bus.m_enable_wreg_o, bus.m_write_reg_o5});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    tick();
    obs = 64'({bus.w_enable_wreg_o, bus.w_write_reg_o5});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
  endtask

  task automatic test_forward();
    logic [4:0] rda[4];
    logic [4:0] rdb[4];
    logic [4:0] rsc[4];
    logic [4:0] rtc[4];
    logic [1:0] exp_d[4];
    logic [3:0] exp_e[4];
    rda   = '{5'd3, 5'd3, 5'd0, 5'd5};
    rdb   = '{5'd3, 5'd4, 5'd0, 5'd6};
    rsc   = '{5'd3, 5'd3, 5'd0, 5'd7};
    rtc   = '{5'd3, 5'd4, 5'd0, 5'd5};
    exp_d = '{2'b11, 2'b10, 2'b00, 2'b01};
    exp_e = '{4'b1010, 4'b0110, 4'b0000, 4'b0001};
    for (int c = 0; c < 4; c++) begin
      tick();
      drive_d(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, rda[c]);
      tick();
      drive_d(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, rdb[c]);
      tick();
      drive_d(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, rsc[c], rtc[c], 5'd0);
      push_exp($sformatf("fwd_d_case%0d", c), 64'(exp_d[c]));
      push_exp($sformatf("fwd_e_case%0d", c), 64'(exp_e[c]));
      #1;
      obs = 64'({bus.forward_ad_o, bus.forward_bd_o});
      it = sb.pop_front();
      checks++;
      if (obs !== it.exp) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
      end
      tick();
      clear_d();
      obs = 64'({bus.forward_ae_o2, bus.forward_be_o2});
      it = sb.pop_front();
      checks++;
      if (obs !== it.exp) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
      end
      tick();
      tick();
    end
  endtask

  task automatic test_load_use();
    tick();
    drive_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 5'd7, 5'd0);
    tick();
    drive_d(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 5'd2, 5'd7, 5'd8);
    push_exp("lu_stall", 64'b1110);
    #1;
    obs = 64'({bus.stall_f_o, bus.stall_d_o, bus.flush_e_o, bus.flush_d_o});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    tick();
    bump_bubble();
    push_exp("lu_bubble", 64'({12'd0, 16'(exp_bubbles)}));
    push_exp("lu_release", 64'({1'b0, 1'b1, 5'd7}));
    obs = 64'({bus.e_mem_to_reg_o, bus.e_enable_wmem_o, bus.e_b_alu_input_o,
               bus.e_enable_wreg_o, bus.e_apply_shift_o, bus.e_alu_alt_ctrl_o2,
               bus.e_write_reg_o5, bus.bubble_cnt_o});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    obs = 64'({bus.stall_f_o, bus.m_mem_to_reg_o, bus.m_write_reg_o5});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    tick();
    clear_d();
    push_exp("lu_issue", 64'({1'b1, 5'd8, 2'b01}));
    obs = 64'({bus.e_enable_wreg_o, bus.e_write_reg_o5, bus.forward_be_o2});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    // Load into $0 still stalls a reader of $0.
    tick();
    drive_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    clear_d();
    push_exp("lu_r0_stall", 64'd1);
    #1;
    obs = 64'(bus.stall_f_o);
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    tick();
    bump_bubble();
    push_exp("lu_r0_count", 64'({1'b0, 16'(exp_bubbles)}));
    obs = 64'({bus.stall_f_o, bus.bubble_cnt_o});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
  endtask

  task automatic test_branch();
    tick();
    drive_d(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 5'd1, 5'd2);
    tick();
    drive_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 5'd2, 5'd9, 5'd0);
    push_exp("br_alu_stall", 64'b1110);
    #1;
    obs = 64'({bus.stall_f_o, bus.stall_d_o, bus.flush_e_o, bus.flush_d_o});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    tick();
    bump_bubble();
    push_exp("br_alu_release", 64'b0101);
    obs = 64'({bus.stall_f_o, bus.forward_ad_o, bus.forward_bd_o, bus.flush_d_o});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    tick();
    drive_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 5'd4, 5'd0);
    tick();
    clear_d();
    tick();
    drive_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 5'd0);
    push_exp("br_load_stall", 64'b10);
    #1;
    obs = 64'({bus.stall_f_o, bus.flush_d_o});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    tick();
    bump_bubble();
    push_exp("br_load_release", 64'b001);
    obs = 64'({bus.stall_f_o, bus.forward_ad_o, bus.flush_d_o});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    tick();
    drive_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    push_exp("jump_flush", 64'({1'b0, 1'b1, 16'(exp_bubbles)}));
    #1;
    obs = 64'({bus.stall_f_o, bus.flush_d_o, bus.bubble_cnt_o});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    tick();
    clear_d();
  endtask

  task automatic test_saturation();
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    push_exp("sat_reset", 64'd0);
    obs = 64'({bus.bubble_cnt_o, bus2.bubble_cnt_o, bus.e_enable_wreg_o, bus.m_enable_wreg_o,
               bus.w_enable_wreg_o});
    it = sb.pop_front();
    checks++;
    if (obs !== it.exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
    end
    #2 rst_ni = 1'b1;
    exp_bubbles = 0;
    exp_sat     = 2'd0;
    // A self-dependent load held in D stalls every other cycle.
    drive_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      push_exp($sformatf("sat_stall%0d", k), 64'd1);
      obs = 64'(bus.flush_e_o);
      it = sb.pop_front();
      checks++;
      if (obs !== it.exp) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
      end
      tick();
      bump_bubble();
      push_exp($sformatf("sat_count%0d", k), 64'({16'(exp_bubbles), exp_sat}));
      obs = 64'({bus.bubble_cnt_o, bus2.bubble_cnt_o});
      it = sb.pop_front();
      checks++;
      if (obs !== it.exp) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h", it.name, obs, it.exp);
      end
    end
    clear_d();
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_forward();
    test_load_use();
    test_branch();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Downstream partner of the decode-stage controller: consumes its per-instruction control word and carries it through the D->E, E->M and M->W pipeline registers.
- Detects load-use and branch-in-decode hazards, then drives stall, flush and forwarding selects back toward fetch, decode and execute.
- Counts inserted bubbles for performance monitoring.
- Sits between the controller/register-file read in DECODE and the datapath muxes in EX/MEM/WB.

Parameters:
CNT_W, 16, width of saturating bubble counter

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
mem_to_reg_i  in  1  D-stage control from controller
enable_wmem_i  in  1  D-stage control
b_alu_input_i  in  1  D-stage control
reg_dst_rtrd_i  in  1  D-stage control: 1 selects rd, 0 selects rt
enable_wreg_i  in  1  D-stage control
apply_shift_i  in  1  D-stage control
alu_alt_ctrl_i2  in  2  D-stage control
branch_i  in  1  D-stage instruction is a branch
pc_beq_i  in  1  branch taken, resolved in D
pc_j_i  in  1  jump in D
rs_d_i5, rt_d_i5, rd_d_i5  in  5 each  D-stage register numbers
e_mem_to_reg_o, e_enable_wmem_o, e_b_alu_input_o, e_enable_wreg_o, e_apply_shift_o  out  1 each  E-stage controls
e_alu_alt_ctrl_o2  out  2  E-stage ALU control
e_write_reg_o5  out  5  E destination register
m_mem_to_reg_o, m_enable_wmem_o, m_enable_wreg_o  out  1 each  M-stage controls
m_write_reg_o5  out  5  M destination register
w_mem_to_reg_o, w_enable_wreg_o  out  1 each  W-stage controls
w_write_reg_o5  out  5  W destination register
stall_f_o, stall_d_o  out  1 each  hold PC / hold IF->D register
flush_e_o  out  1  bubble into E next edge
flush_d_o  out  1  kill IF->D register (taken branch/jump)
forward_ad_o, forward_bd_o  out  1 each  D-stage comparator forwarding from M
forward_ae_o2, forward_be_o2  out  2 each  E-stage ALU operand select
bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Async reset (rst_ni=0): all E/M/W registers, including the internal E-stage rs/rt/rd copies, clear to 0 immediately. bubble_cnt_o=0. Reset mid-stream discards all in-flight controls, with no partial state.
- Combinational outputs depend only on registered state and D inputs, so they follow reset within the same cycle.
- D->E register: on each edge, loads all D controls and rs/rt/rd. If flush_e_o=1, it loads all zeros instead (bubble).
- E->M and M->W registers: advance every edge, unconditionally.
- e_write_reg_o5 is combinational in E: reg_dst_rtrd_e ? rd_e : rt_e.
- Latency: a D control appears at E outputs 1 cycle later, at M after 2 cycles, at W after 3 cycles.
- Forward E, operand A (operand B identical, using rt_e):
  - 2'b10 if rs_e!=0 && rs_e==m_write_reg && m_enable_wreg.
  - else 2'b01 if rs_e!=0 && rs_e==w_write_reg && w_enable_wreg.
  - else 2'b00.
  - M has priority over W when both match.
- forward_ad_o = rs_d!=0 && rs_d==m_write_reg && m_enable_wreg. forward_bd_o is the same with rt_d.
- lw_stall = e_mem_to_reg && (rt_e==rs_d || rt_e==rt_d).
- br_stall = branch_i && ((e_enable_wreg && e_write_reg∈{rs_d,rt_d}) || (m_mem_to_reg && m_write_reg∈{rs_d,rt_d})).
- stall = lw_stall | br_stall. stall_f_o = stall_d_o = flush_e_o = stall.
- flush_d_o = (pc_beq_i | pc_j_i) & ~stall. A taken branch that is stalled is not flushed until its operands are ready.
- bubble_cnt_o increments on every edge where flush_e_o=1 and saturates at 2^CNT_W-1 with no wrap.
- Register 0 never triggers forwarding. It can trigger a stall: lw to $0 stalls conservatively.

Test Plan:
- Reset: drive all inputs with random values, pulse rst_ni low mid-cycle -> all E/M/W outputs and bubble_cnt_o read 0 before the next edge.
- Latency: ALU op enable_wreg_i=1, reg_dst_rtrd_i=1, rd=5 -> e_write_reg_o5=5 at cycle 1, m_write_reg_o5=5 at cycle 2, w_write_reg_o5=5 and w_enable_wreg_o=1 at cycle 3.
- Forwarding priority: M writes r3 and W writes r3 while E reads rs=3 -> forward_ae_o2=2'b10. With M writing r4 instead -> 2'b01. With rs=0 -> 2'b00.
- Load-use: lw into r7 in E, D reads rt=7 -> stall_f_o=stall_d_o=flush_e_o=1 for one cycle, next E controls all 0, bubble_cnt_o=1.
- Branch hazard: branch_i=1, pc_beq_i=1, rs_d=2, ALU op writing r2 in E -> stall=1 and flush_d_o=0. Next cycle stall=0, forward_ad_o=1, flush_d_o=1.
- Saturation: CNT_W=2, force 5 consecutive load-use stalls -> bubble_cnt_o reaches 3 and holds at 3.
